// File: rtl/a2d_sched.sv
`default_nettype none
// ============================================================================
// Module   : a2d_sched
// Purpose  : Round-robin conversion scheduler for the shared SPI A2D. Each
//            nxt pulse runs a command frame (channel select) followed by a
//            read frame. The 12-bit result is stored per channel.
// Revision : 1.0  initial release
// ============================================================================
module a2d_sched #(
  parameter logic [2:0]  CH_LFT   = 3'd0,
  parameter logic [2:0]  CH_RGHT  = 3'd4,
  parameter logic [2:0]  CH_STEER = 3'd5,
  parameter logic [2:0]  CH_BATT  = 3'd6,
  parameter int unsigned DEAD_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
  output logic [1:0]  chnl_idx
);

  // The gap counter holds "cycles still to wait after this one", so the
  // read wrt lands exactly DEAD_CYC cycles after the state leaves CMD_WAIT.
  localparam logic [3:0] C_GAP_LOAD = (DEAD_CYC == 0) ? 4'd0 : 4'(DEAD_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CMD_WAIT = 2'd1,
    ST_GAP      = 2'd2,
    ST_RD_WAIT  = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_gap_cnt;
  logic        r_wrt;
  logic [15:0] r_cmd;
  logic [11:0] r_lft_ld;
  logic [11:0] r_rght_ld;
  logic [11:0] r_steer_pot;
  logic [11:0] r_batt;
  logic        r_cnv_cmplt;
  logic [1:0]  r_chnl_idx;
  logic [2:0]  w_ch;
  logic        w_unused_rd_hi;

  // Upper nibble of the read word carries no result information.
  assign w_unused_rd_hi = ^rd_data[15:12];

  // Map the round-robin pointer onto the physical A2D channel number.
  always_comb begin
    w_ch = CH_LFT;
    case (r_chnl_idx)
      2'd0:    w_ch = CH_LFT;
      2'd1:    w_ch = CH_RGHT;
      2'd2:    w_ch = CH_STEER;
      default: w_ch = CH_BATT;
    endcase
  end

  // Conversion sequencer: command frame, dead gap, read frame, capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gap_cnt   <= 4'd0;
      r_wrt       <= 1'b0;
      r_cmd       <= 16'h0000;
      r_lft_ld    <= 12'h000;
      r_rght_ld   <= 12'h000;
      r_steer_pot <= 12'h000;
      r_batt      <= 12'h000;
      r_cnv_cmplt <= 1'b0;
      r_chnl_idx  <= 2'd0;
    end else begin
      r_wrt       <= 1'b0;
      r_cnv_cmplt <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (nxt) begin
            r_wrt   <= 1'b1;
            r_cmd   <= {2'b00, w_ch, 11'h000};
            r_state <= ST_CMD_WAIT;
          end
        end
        ST_CMD_WAIT: begin
          if (done) begin
            if (DEAD_CYC == 0) begin
              // No gap requested: issue the read frame right away.
              r_wrt   <= 1'b1;
              r_state <= ST_RD_WAIT;
            end else begin
              r_gap_cnt <= C_GAP_LOAD;
              r_state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == 4'd0) begin
            r_wrt   <= 1'b1;
            r_state <= ST_RD_WAIT;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        ST_RD_WAIT: begin
          if (done) begin
            case (r_chnl_idx)
              2'd0:    r_lft_ld    <= rd_data[11:0];
              2'd1:    r_rght_ld   <= rd_data[11:0];
              2'd2:    r_steer_pot <= rd_data[11:0];
              default: r_batt      <= rd_data[11:0];
            endcase
            r_cnv_cmplt <= 1'b1;
            r_chnl_idx  <= r_chnl_idx + 2'd1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wrt       = r_wrt;
  assign cmd       = r_cmd;
  assign lft_ld    = r_lft_ld;
  assign rght_ld   = r_rght_ld;
  assign steer_pot = r_steer_pot;
  assign batt      = r_batt;
  assign cnv_cmplt = r_cnv_cmplt;
  assign chnl_idx  = r_chnl_idx;

endmodule
`default_nettype wire
